// File: rtl/melody_ctrl_if.sv
// Control/status bundle between a melody player and its host.
// The host drives start/stop/key; the player returns tone and status outputs.
interface melody_ctrl_if;
  logic        start;
  logic        stop;
  logic [6:0]  key;
  logic [17:0] tone_period;
  logic        tone_en;
  logic [2:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, key,
    input  tone_period, tone_en, note_idx, busy, done
  );

  modport slave (
    input  start, stop, key,
    output tone_period, tone_en, note_idx, busy, done
  );
endinterface

// File: rtl/melody_ctrl.sv
// Plays a fixed ROM melody (note, gap, next note) with stop, key-override and pause.
// Define MELODY_LOOP_EN to replay the melody continuously until stop or reset.
module melody_ctrl #(
  parameter logic [24:0] BEAT_CNT = 25'd24_999_999,
  parameter logic [19:0] GAP_CNT  = 20'd999_999,
  parameter logic [17:0] DO       = 18'd190_839,
  parameter logic [17:0] RE       = 18'd170_067,
  parameter logic [17:0] MI       = 18'd151_514,
  parameter logic [17:0] FA       = 18'd143_266,
  parameter logic [17:0] SO       = 18'd127_551,
  parameter logic [17:0] LA       = 18'd113_636,
  parameter logic [17:0] SI       = 18'd101_214,
  parameter logic [4:0]  LEN      = 5'd14
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  melody_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSE} state_t;

  state_t      state, nxt_state, resume, nxt_resume, eff;
  logic [3:0]  ptr, nxt_ptr;
  logic [24:0] beat_cnt, nxt_beat_cnt;
  logic [1:0]  beat_num, nxt_beat_num;
  logic [19:0] gap_cnt, nxt_gap_cnt;
  logic        nxt_done;
  logic        last_entry;
  logic        key_hit;
  logic [2:0]  key_idx;
  logic [17:0] out_period;
  logic        out_en;
  logic [2:0]  out_idx;

  logic [17:0] period_q;
  logic        en_q, busy_q, done_q;
  logic [2:0]  idx_q;

  // Melody ROM entry: {note_idx, beats-1}.
  function automatic logic [4:0] rom(input logic [3:0] a);
    case (a)
      4'd0, 4'd1:   rom = {3'd1, 2'd0};
      4'd2, 4'd3:   rom = {3'd5, 2'd0};
      4'd4, 4'd5:   rom = {3'd6, 2'd0};
      4'd6:         rom = {3'd5, 2'd1};
      4'd7, 4'd8:   rom = {3'd4, 2'd0};
      4'd9, 4'd10:  rom = {3'd3, 2'd0};
      4'd11, 4'd12: rom = {3'd2, 2'd0};
      4'd13:        rom = {3'd1, 2'd1};
      default:      rom = {3'd0, 2'd0};
    endcase
  endfunction

  function automatic logic [2:0] rom_note(input logic [3:0] a);
    logic [4:0] e;
    e = rom(a);
    return e[4:2];
  endfunction

  function automatic logic [1:0] rom_beats(input logic [3:0] a);
    logic [4:0] e;
    e = rom(a);
    return e[1:0];
  endfunction

  function automatic logic [17:0] note_period(input logic [2:0] n);
    case (n)
      3'd1:    note_period = DO;
      3'd2:    note_period = RE;
      3'd3:    note_period = MI;
      3'd4:    note_period = FA;
      3'd5:    note_period = SO;
      3'd6:    note_period = LA;
      3'd7:    note_period = SI;
      default: note_period = 18'd0;
    endcase
  endfunction

  assign last_entry = ({1'b0, ptr} == LEN - 5'd1);
  assign key_hit    = |bus.key;

  // Lowest set key bit wins.
  always_comb begin
    key_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (bus.key[i]) key_idx = 3'(i + 1);
    end
  end

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    nxt_state    = state;
    nxt_resume   = resume;
    nxt_ptr      = ptr;
    nxt_beat_cnt = beat_cnt;
    nxt_beat_num = beat_num;
    nxt_gap_cnt  = gap_cnt;
    nxt_done     = 1'b0;
    // While paused, a key release acts on the frozen state in the same edge.
    eff          = (state == PAUSE) ? resume : state;

    if (state == IDLE) begin
      if (bus.start && !bus.stop) begin
        nxt_state    = PLAY;
        nxt_ptr      = 4'd0;
        nxt_beat_cnt = 25'd0;
        nxt_beat_num = 2'd0;
        nxt_gap_cnt  = 20'd0;
      end
    end else if (bus.stop) begin
      nxt_state    = IDLE;
      nxt_resume   = IDLE;
      nxt_ptr      = 4'd0;
      nxt_beat_cnt = 25'd0;
      nxt_beat_num = 2'd0;
      nxt_gap_cnt  = 20'd0;
    end else if (key_hit) begin
      nxt_state  = PAUSE;
      nxt_resume = eff;
    end else if (eff == PLAY) begin
      nxt_state = PLAY;
      if (beat_cnt == BEAT_CNT) begin
        nxt_beat_cnt = 25'd0;
        if (beat_num == rom_beats(ptr)) begin
          nxt_beat_num = 2'd0;
          nxt_gap_cnt  = 20'd0;
          nxt_state    = GAP;
        end else begin
          nxt_beat_num = beat_num + 2'd1;
        end
      end else begin
        nxt_beat_cnt = beat_cnt + 25'd1;
      end
    end else begin
      nxt_state = GAP;
      if (gap_cnt == GAP_CNT) begin
        nxt_gap_cnt = 20'd0;
        if (last_entry) begin
          nxt_done = 1'b1;
          nxt_ptr  = 4'd0;
`ifdef MELODY_LOOP_EN
          nxt_state = PLAY;
`else
          nxt_state = IDLE;
`endif
        end else begin
          nxt_ptr   = ptr + 4'd1;
          nxt_state = PLAY;
        end
      end else begin
        nxt_gap_cnt = gap_cnt + 20'd1;
      end
    end
  end

  // Outputs are decoded from the next state so the registers show it on the same edge.
  always_comb begin
    out_period = 18'd0;
    out_en     = 1'b0;
    out_idx    = 3'd0;
    if (key_hit) begin
      out_en     = 1'b1;
      out_idx    = key_idx;
      out_period = note_period(key_idx);
    end else if (nxt_state == PLAY || nxt_state == GAP) begin
      out_idx    = rom_note(nxt_ptr);
      out_period = note_period(out_idx);
      out_en     = (nxt_state == PLAY) && (out_idx != 3'd0);
    end
  end

  // NOTE: reset is synchronous and only checked inside the clocked block.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      resume   <= IDLE;
      ptr      <= 4'd0;
      beat_cnt <= 25'd0;
      beat_num <= 2'd0;
      gap_cnt  <= 20'd0;
      period_q <= 18'd0;
      en_q     <= 1'b0;
      idx_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= nxt_state;
      resume   <= nxt_resume;
      ptr      <= nxt_ptr;
      beat_cnt <= nxt_beat_cnt;
      beat_num <= nxt_beat_num;
      gap_cnt  <= nxt_gap_cnt;
      period_q <= out_period;
      en_q     <= out_en;
      idx_q    <= out_idx;
      busy_q   <= (nxt_state != IDLE);
      done_q   <= nxt_done;
    end
  end

  assign bus.tone_period = period_q;
  assign bus.tone_en     = en_q;
  assign bus.note_idx    = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
